// File: rtl/jk_bank_ctrl_if.sv
// Command and status bundle for the JK bank controller.
// The command source uses the master modport. The controller uses the slave modport.
interface jk_bank_ctrl_if #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 8
);
  logic               cmd_valid;
  logic               cmd_ready;
  logic [1:0]         cmd_op;
  logic [WIDTH-1:0]   cmd_data;
  logic [CNT_W-1:0]   cmd_steps;
  logic [2*WIDTH-1:0] jk;
  logic [WIDTH-1:0]   q;
  logic               busy;
  logic               done;

  modport master (
    output cmd_valid, cmd_op, cmd_data, cmd_steps,
    input  cmd_ready, jk, q, busy, done
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_data, cmd_steps,
    output cmd_ready, jk, q, busy, done
  );
endinterface

// File: rtl/jk_bank_ctrl.sv
// Sequences a bank of JK flip-flops from LOAD/CLEAR/COUNT/NOP commands.
// The bank state changes only through the per-bit J/K next-state equation.
module jk_bank_ctrl #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 8
) (
  input  logic            clk,
  input  logic            rst,
  jk_bank_ctrl_if.slave   bus
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam logic [1:0] OP_NOP   = 2'b00;
  localparam logic [1:0] OP_LOAD  = 2'b01;
  localparam logic [1:0] OP_CLEAR = 2'b10;
  localparam logic [1:0] OP_COUNT = 2'b11;

  state_t             state_q;
  logic               ready_q;
  logic               busy_q;
  logic               done_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [1:0]         op_q;
  logic [WIDTH-1:0]   data_q;
  logic [WIDTH-1:0]   q_q;
  logic [WIDTH-1:0]   q_d;
  logic [WIDTH-1:0]   j_d;
  logic [WIDTH-1:0]   k_d;
  logic               accept;
  logic               run_last;

  // Bit i of the result is set when every bit below i in q is 1.
  function automatic logic [WIDTH-1:0] lower_ones(input logic [WIDTH-1:0] q);
    logic [WIDTH-1:0] m;
    m[0] = 1'b1;
    for (int i = 1; i < WIDTH; i++) begin
      m[i] = m[i-1] & q[i-1];
    end
    return m;
  endfunction

  function automatic logic [WIDTH-1:0] jk_next(input logic [WIDTH-1:0] q,
                                               input logic [WIDTH-1:0] j,
                                               input logic [WIDTH-1:0] k);
    return (j & ~q) | (~k & q);
  endfunction

  function automatic logic [2*WIDTH-1:0] pack_jk(input logic [WIDTH-1:0] j,
                                                 input logic [WIDTH-1:0] k);
    logic [2*WIDTH-1:0] v;
    for (int i = 0; i < WIDTH; i++) begin
      v[2*i+1] = j[i];
      v[2*i]   = k[i];
    end
    return v;
  endfunction

  assign accept   = (state_q == ST_IDLE) && bus.cmd_valid && ready_q;
  assign run_last = (op_q != OP_COUNT) || (cnt_q <= CNT_W'(1));

  // The drive is nonzero only in RUN. This keeps q held in IDLE and DONE without a separate enable.
  always_comb begin
    j_d = '0;
    k_d = '0;
    if (state_q == ST_RUN) begin
      case (op_q)
        OP_LOAD: begin
          j_d = data_q;
          k_d = ~data_q;
        end
        OP_CLEAR: begin
          k_d = '1;
        end
        OP_COUNT: begin
          if (cnt_q != '0) begin
            j_d = lower_ones(q_q);
            k_d = lower_ones(q_q);
          end
        end
        default: begin
          j_d = '0;
          k_d = '0;
        end
      endcase
    end
  end

  assign q_d = jk_next(q_q, j_d, k_d);

  // Control FSM and bank state.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      ready_q <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      cnt_q   <= '0;
      q_q     <= '0;
    end else begin
      q_q <= q_d;
      case (state_q)
        ST_IDLE: begin
          if (accept) begin
            state_q <= ST_RUN;
            ready_q <= 1'b0;
            busy_q  <= 1'b1;
            cnt_q   <= bus.cmd_steps;
          end
        end
        ST_RUN: begin
          if (run_last) begin
            state_q <= ST_DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end else begin
            cnt_q <= cnt_q - CNT_W'(1);
          end
        end
        ST_DONE: begin
          state_q <= ST_IDLE;
          done_q  <= 1'b0;
          ready_q <= 1'b1;
        end
        default: begin
          state_q <= ST_IDLE;
          ready_q <= 1'b1;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  // The command payload is captured at accept. It has no reset because it is read only in RUN.
  always_ff @(posedge clk) begin
    if (accept) begin
      op_q   <= bus.cmd_op;
      data_q <= bus.cmd_data;
    end
  end

  assign bus.cmd_ready = ready_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.q         = q_q;
  assign bus.jk        = pack_jk(j_d, k_d);

endmodule

// File: tb/tb_jk_bank_ctrl.sv
// Bench for jk_bank_ctrl: directed table, reset/handshake sequences, and random commands
// checked against an arithmetic model of the bank.
module tb_jk_bank_ctrl;
  localparam int WIDTH = 4;
  localparam int CNT_W = 8;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  jk_bank_ctrl_if #(.WIDTH(WIDTH), .CNT_W(CNT_W)) bus ();

  jk_bank_ctrl #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int acc_cnt  = 0;
  logic [WIDTH-1:0] mq;

  typedef struct {
    logic [1:0]       op;
    logic [WIDTH-1:0] data;
    logic [CNT_W-1:0] steps;
    logic [WIDTH-1:0] exp_q;
  } vec_t;
  vec_t vecs [10];

  always @(posedge clk) begin
    if (rst && bus.cmd_valid && bus.cmd_ready) acc_cnt++;
  end

  initial begin
    #500000;
    $display("FAIL timeout: simulation still running at %0t, required finish earlier", $time);
    $fatal(1, "timeout");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [2*WIDTH-1:0] spread(input logic [WIDTH-1:0] j, input logic [WIDTH-1:0] k);
    logic [2*WIDTH-1:0] v;
    for (int i = 0; i < WIDTH; i++) begin
      v[2*i+1] = j[i];
      v[2*i]   = k[i];
    end
    return v;
  endfunction

  // Expected drive. During COUNT the toggled bits of an increment are exactly q ^ (q+1).
  function automatic logic [2*WIDTH-1:0] exp_jk(input logic [1:0] op, input logic [WIDTH-1:0] data,
                                                input logic [WIDTH-1:0] q, input logic cnt_active);
    logic [WIDTH-1:0] m;
    case (op)
      2'b01:   return spread(data, ~data);
      2'b10:   return spread('0, '1);
      2'b11: begin
        if (!cnt_active) return '0;
        m = q ^ (q + 1'b1);
        return spread(m, m);
      end
      default: return '0;
    endcase
  endfunction

  task automatic run_cmd(input logic [1:0] op, input logic [WIDTH-1:0] data, input logic [CNT_W-1:0] steps);
    int guard;
    int n;
    logic cnt_active;
    guard = 0;
    while (!bus.cmd_ready && guard < 50) begin
      tick();
      guard++;
    end
    chk("ready_before_cmd", bus.cmd_ready, 1);
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = op;
    bus.cmd_data  = data;
    bus.cmd_steps = steps;
    tick();
    bus.cmd_valid = 1'b0;
    bus.cmd_op    = 2'($urandom);
    bus.cmd_data  = WIDTH'($urandom);
    bus.cmd_steps = CNT_W'($urandom);
    cnt_active = (op == 2'b11) && (steps != 0);
    n = cnt_active ? int'(steps) : 1;
    for (int c = 0; c < n; c++) begin
      chk("run_busy", bus.busy, 1);
      chk("run_ready", bus.cmd_ready, 0);
      chk("run_done", bus.done, 0);
      chk("run_jk", bus.jk, exp_jk(op, data, mq, cnt_active));
      case (op)
        2'b01:   mq = data;
        2'b10:   mq = '0;
        2'b11:   if (cnt_active) mq = mq + 1'b1;
        default: mq = mq;
      endcase
      tick();
      chk("run_q", bus.q, mq);
    end
    chk("done_pulse", bus.done, 1);
    chk("done_busy", bus.busy, 0);
    chk("done_jk", bus.jk, 0);
    chk("done_ready", bus.cmd_ready, 0);
    tick();
    chk("post_done", bus.done, 0);
    chk("post_ready", bus.cmd_ready, 1);
  endtask

  initial begin
    int acc0;
    vecs[0] = '{2'b01, 4'b1010, 8'd0,  4'b1010};
    vecs[1] = '{2'b01, 4'b1101, 8'd0,  4'b1101};
    vecs[2] = '{2'b11, 4'b0000, 8'd5,  4'b0010};
    vecs[3] = '{2'b01, 4'b1111, 8'd0,  4'b1111};
    vecs[4] = '{2'b10, 4'b0110, 8'd0,  4'b0000};
    vecs[5] = '{2'b11, 4'b1001, 8'd0,  4'b0000};
    vecs[6] = '{2'b00, 4'b0111, 8'd3,  4'b0000};
    vecs[7] = '{2'b11, 4'b0000, 8'd17, 4'b0001};
    vecs[8] = '{2'b01, 4'b1111, 8'd0,  4'b1111};
    vecs[9] = '{2'b11, 4'b0000, 8'd1,  4'b0000};

    bus.cmd_valid = 1'b0;
    bus.cmd_op    = 2'b00;
    bus.cmd_data  = '0;
    bus.cmd_steps = '0;

    // Reset state
    rst = 1'b0;
    tick();
    tick();
    chk("rst_q", bus.q, 0);
    chk("rst_jk", bus.jk, 0);
    chk("rst_ready", bus.cmd_ready, 1);
    chk("rst_busy", bus.busy, 0);
    chk("rst_done", bus.done, 0);
    rst = 1'b1;
    tick();
    chk("idle_q", bus.q, 0);
    chk("idle_ready", bus.cmd_ready, 1);
    mq = '0;

    // Directed table
    for (int i = 0; i < 10; i++) begin
      run_cmd(vecs[i].op, vecs[i].data, vecs[i].steps);
      chk("table_q", bus.q, vecs[i].exp_q);
    end

    // Reset during COUNT aborts without a done pulse
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = 2'b11;
    bus.cmd_steps = 8'd8;
    tick();
    bus.cmd_valid = 1'b0;
    for (int c = 0; c < 3; c++) tick();
    chk("abort_pre_q", bus.q, 3);
    chk("abort_pre_busy", bus.busy, 1);
    rst = 1'b0;
    tick();
    chk("abort_q", bus.q, 0);
    chk("abort_busy", bus.busy, 0);
    chk("abort_done", bus.done, 0);
    chk("abort_ready", bus.cmd_ready, 1);
    chk("abort_jk", bus.jk, 0);
    rst = 1'b1;
    tick();
    chk("abort_no_done", bus.done, 0);
    chk("abort_q_hold", bus.q, 0);
    mq = '0;

    // cmd_valid held high across COUNT 3, then a LOAD
    acc0 = acc_cnt;
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = 2'b11;
    bus.cmd_data  = 4'b0000;
    bus.cmd_steps = 8'd3;
    tick();
    bus.cmd_op   = 2'b01;
    bus.cmd_data = 4'b0110;
    for (int c = 0; c < 3; c++) begin
      chk("hold_busy", bus.busy, 1);
      tick();
    end
    chk("hold_q", bus.q, 3);
    chk("hold_done", bus.done, 1);
    chk("hold_ready_in_done", bus.cmd_ready, 0);
    tick();
    chk("hold_ready_idle", bus.cmd_ready, 1);
    chk("hold_busy_idle", bus.busy, 0);
    tick();
    chk("hold_second_busy", bus.busy, 1);
    bus.cmd_valid = 1'b0;
    tick();
    chk("hold_second_q", bus.q, 4'b0110);
    chk("hold_second_done", bus.done, 1);
    tick();
    chk("hold_final_ready", bus.cmd_ready, 1);
    chk("hold_accepts", acc_cnt - acc0, 2);
    mq = 4'b0110;

    // Random commands
    for (int r = 0; r < 40; r++) begin
      logic [1:0]       op;
      logic [WIDTH-1:0] data;
      logic [CNT_W-1:0] steps;
      op    = 2'($urandom_range(0, 3));
      data  = WIDTH'($urandom);
      steps = ($urandom_range(0, 3) == 0) ? CNT_W'($urandom_range(0, 20)) : CNT_W'($urandom_range(0, 4));
      run_cmd(op, data, steps);
      chk("rand_q", bus.q, mq);
      repeat ($urandom_range(0, 2)) tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
